// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple-counter timer arbiter: FSM encoding and
// the width of the external ripple counter.
package ripple_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TICK,
        S_SETTLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// ptr, wrapping around. idx is 0 when no request is set.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx
);

    always_comb begin
        logic found;
        int   j;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                idx   = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_timer_arbiter.sv
// Arbitrates NREQ requesters onto one external 4-bit ripple counter: the winner
// gets a clear, then len ticks, each followed by SETTLE idle cycles before the
// counter output is checked against a shadow count.
module ripple_timer_arbiter
    import ripple_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [CNT_W*NREQ-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err,
    output logic                  cnt_rst,
    output logic                  cnt_tick,
    input  logic [CNT_W-1:0]      cnt_q
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, rr_q, rr_d, pick_idx, idx_next;
    logic [CNT_W-1:0]  len_q, len_d, shadow_q, shadow_d, len_sel;
    logic [SW-1:0]     settle_q, settle_d;
    logic              err_q, err_d, cnt_rst_q;
    logic              req_hold, settle_last;
    logic [NREQ-1:0]   onehot;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (rr_q),
        .idx (pick_idx)
    );

    always_comb begin
        len_sel  = '0;
        req_hold = 1'b0;
        onehot   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) len_sel = len[i*CNT_W +: CNT_W];
            if (idx_q == IW'(i)) begin
                req_hold  = req[i];
                onehot[i] = 1'b1;
            end
        end
    end

    assign idx_next    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
    assign settle_last = (settle_q == SW'(SETTLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            shadow_q  <= '0;
            settle_q  <= '0;
            rr_q      <= '0;
            err_q     <= 1'b0;
            cnt_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            shadow_q  <= shadow_d;
            settle_q  <= settle_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
            cnt_rst_q <= (state_d == S_CLEAR);
        end
    end

    // A dropped request aborts the run ahead of any completion decision.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        shadow_d = shadow_q;
        settle_d = settle_q;
        rr_d     = rr_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    idx_d   = pick_idx;
                    len_d   = len_sel;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                shadow_d = '0;
                if (!req_hold) begin
                    state_d = S_IDLE;
                    rr_d    = idx_next;
                end else begin
                    state_d = (len_q == '0) ? S_DONE : S_TICK;
                end
            end
            S_TICK: begin
                shadow_d = shadow_q + CNT_W'(1);
                settle_d = '0;
                if (!req_hold) begin
                    state_d = S_IDLE;
                    rr_d    = idx_next;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + SW'(1);
                if (settle_last && (cnt_q != shadow_q)) err_d = 1'b1;
                if (!req_hold) begin
                    state_d = S_IDLE;
                    rr_d    = idx_next;
                end else if (settle_last) begin
                    state_d = (shadow_q == len_q) ? S_DONE : S_TICK;
                end
            end
            S_DONE: begin
                rr_d    = idx_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt      = '0;
        done     = '0;
        busy     = (state_q != S_IDLE);
        cnt_tick = (state_q == S_TICK);
        if (state_q == S_CLEAR || state_q == S_TICK || state_q == S_SETTLE) gnt = onehot;
        if (state_q == S_DONE) done = onehot;
    end

    assign err     = err_q;
    assign cnt_rst = cnt_rst_q;

endmodule

// File: tb/tb_ripple_timer_arbiter.sv
// Randomized bench for ripple_timer_arbiter with a run-level reference model
// (cycle offset within a run) and a local model of the ripple counter.
module tb_ripple_timer_arbiter;

    localparam int NREQ = 3;
    localparam int S    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] len = '0;
    logic [NREQ-1:0]   gnt, done;
    logic              busy, err, cnt_rst, cnt_tick;
    logic [3:0]        cnt_q, rc;
    logic              fault = 1'b0;

    int checks = 0;
    int errors = 0;

    // model of one run: m_t counts cycles since the first grant cycle
    int  m_busy = 0, m_t = 0, m_idx = 0, m_len = 0, m_rr = 0;
    bit  m_err = 0, m_rst_hold = 1;
    int  cyc = 0, gstart = 0, tick_cnt = 0;
    bit  done_evt = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    ripple_timer_arbiter #(.NREQ(NREQ), .SETTLE(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .len      (len),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .cnt_rst  (cnt_rst),
        .cnt_tick (cnt_tick),
        .cnt_q    (cnt_q)
    );

    // external ripple counter, with a fault override forcing its output to 0
    always @(posedge cnt_tick or posedge cnt_rst) begin
        if (cnt_rst) rc <= 4'd0;
        else         rc <= rc + 4'd1;
    end
    assign cnt_q = fault ? 4'd0 : rc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step();
        int g, k;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        cyc++;
        g  = 1 + m_len * (S + 1);
        oh = m_busy != 0 ? NREQ'(1 << m_idx) : '0;
        check("gnt", gnt, (m_busy != 0 && m_t < g) ? oh : '0);
        check("done", done, (m_busy != 0 && m_t == g) ? oh : '0);
        check("busy", busy, m_busy != 0);
        check("cnt_tick", cnt_tick,
              m_busy != 0 && m_t >= 1 && m_t < g && ((m_t - 1) % (S + 1)) == 0);
        check("cnt_rst", cnt_rst, m_rst_hold || (m_busy != 0 && m_t == 0));
        check("err", err, m_err);
        if (gnt != '0 && prev_gnt == '0) begin
            gstart   = cyc;
            tick_cnt = 0;
            if (exp_q.size() > 0) check("order", idx_of(gnt), exp_q.pop_front());
        end
        if (cnt_tick) tick_cnt++;
        if (done != '0) begin
            check("latency", cyc - gstart, 1 + m_len * (S + 1));
            check("ticks", tick_cnt, m_len);
        end
        prev_gnt = gnt;
        if (m_busy == 0) begin
            if (req != '0) begin
                for (int d = 0; d < NREQ; d++) begin
                    k = (m_rr + d) % NREQ;
                    if (req[k]) begin
                        m_idx = k;
                        break;
                    end
                end
                m_len  = int'(len[4*m_idx +: 4]);
                m_busy = 1;
                m_t    = 0;
            end
        end else if (m_t == g) begin
            m_busy   = 0;
            m_rr     = (m_idx + 1) % NREQ;
            done_evt = 1;
        end else begin
            if (m_t >= 1 && ((m_t - 1) % (S + 1)) == S) begin
                k = (m_t - 1) / (S + 1) + 1;
                if (int'(cnt_q) != k) m_err = 1;
            end
            if (!req[m_idx]) begin
                m_busy = 0;
                m_rr   = (m_idx + 1) % NREQ;
            end else begin
                m_t++;
            end
        end
        @(posedge clk);
        #1;
        m_rst_hold = 0;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_tick", cnt_tick, 0);
        check("rst_cnt_rst", cnt_rst, 1);
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", cnt_rst, 1);
        check("rst_hold_busy", busy, 0);
        reset = 1'b0;
        m_busy = 0; m_t = 0; m_idx = 0; m_len = 0; m_rr = 0;
        m_err = 0; m_rst_hold = 1;
        exp_q.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            done_evt = 0;
            step();
            if (done_evt) seen++;
        end
        check("runs_done", seen, n);
    endtask

    initial begin
        apply_reset();

        // single run, len0=3
        len = 12'h003; req = 3'b001; exp_q.push_back(2'd0);
        wait_done(1, 40);
        req = '0; step();

        // contention from rr=0
        apply_reset();
        len = {4'd3, 4'd1, 4'd2}; req = 3'b111;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        wait_done(4, 200);
        req = '0; step(); step();

        // zero length on requester 1
        len = 12'h000; req = 3'b010; exp_q.push_back(2'd1);
        wait_done(1, 20);
        req = '0; step();

        // len changes while granted are ignored
        len = 12'h004; req = 3'b001;
        repeat (3) step();
        len = 12'($urandom);
        wait_done(1, 60);
        req = '0; step();

        // abort after the second tick of requester 0
        apply_reset();
        len = {4'd0, 4'd1, 4'd5}; req = 3'b011;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_busy != 0 && m_idx == 0 && m_t == 5) break;
        end
        req = 3'b010;
        wait_done(1, 40);
        req = '0; step();

        // forced counter fault, err sticky across a later clean run
        fault = 1'b1; len = 12'h002; req = 3'b001;
        wait_done(1, 40);
        fault = 1'b0; req = '0; step();
        check("err_set", err, 1);
        len = 12'h001; req = 3'b001;
        wait_done(1, 40);
        req = '0; step();
        check("err_sticky", err, 1);

        // asynchronous reset in the middle of SETTLE
        len = 12'h003; req = 3'b001;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_busy != 0 && m_t == 2) break;
        end
        apply_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            len   = 12'($urandom);
            fault = ($urandom_range(0, 299) == 0);
            if (c == 1500) apply_reset();
            step();
        end
        fault = 1'b0; req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
